// File: rtl/nes_bus_pkg.sv
// Shared NES memory-bus definitions: bus owner encoding, the address driven
// while nobody owns the bus, and the widths of the arbiter's counters.
package nes_bus_pkg;

    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        OWN_HCI  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_TURN = 2'd3
    } owner_e;

    // Unmapped address parked on the bus during turnaround cycles
    localparam logic [15:0] IDLE_ADDR = 16'h5000;

    localparam int unsigned HOLD_W  = 10;
    localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/cpumc_arb.sv
// CPU / debug-host / sprite-DMA arbiter for the shared memory bus.
// Every ownership change passes through one TURN cycle that parks the bus.
// DMA tenures are capped at DMA_MAX cycles, after which the CPU is given at
// least one cycle before DMA may win again.
// Optional feature: define CPUMC_ARB_STATS_EN to add stat_clr_in and a
// saturating CPU stall counter on stall_cnt_out.
module cpumc_arb
    import nes_bus_pkg::*;
#(
    parameter int unsigned DMA_MAX = 513
) (
    input  logic        clk_in,
    input  logic        nrst_in,
    input  logic [15:0] cpu_a_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  cpu_d_in,
    output logic        cpu_rdy_out,
    input  logic        hci_req_in,
    output logic        hci_gnt_out,
    input  logic [15:0] hci_a_in,
    input  logic        hci_r_nw_in,
    input  logic [7:0]  hci_d_in,
    input  logic        dma_req_in,
    output logic        dma_gnt_out,
    input  logic [15:0] dma_a_in,
    input  logic        dma_r_nw_in,
    input  logic [7:0]  dma_d_in,
    output logic [15:0] mc_a_out,
    output logic        mc_r_nw_out,
    output logic [7:0]  mc_d_out,
    input  logic [7:0]  mc_d_in,
    output logic [7:0]  rd_d_out,
    output logic [2:0]  rd_vld_out,
    output logic [1:0]  owner_out
`ifdef CPUMC_ARB_STATS_EN
    ,
    input  logic        stat_clr_in,
    output logic [15:0] stall_cnt_out
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DMA_MAX - 1);

    owner_e              owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                cool_q, cool_d;
    logic                tag_rd_q;
    logic [1:0]          tag_own_q;

    // Owner, DMA hold counter, cooldown flag and read-return tag
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            owner_q   <= OWN_CPU;
            hold_q    <= '0;
            cool_q    <= 1'b0;
            tag_rd_q  <= 1'b0;
            tag_own_q <= '0;
        end else begin
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            cool_q    <= cool_d;
            tag_rd_q  <= (owner_q != OWN_TURN) && mc_r_nw_out;
            tag_own_q <= owner_q;
        end
    end

    // Next owner; the hold counter only survives while DMA keeps the bus
    always_comb begin
        owner_d = owner_q;
        hold_d  = '0;
        cool_d  = cool_q;
        case (owner_q)
            OWN_CPU: begin
                cool_d = 1'b0;
                if (hci_req_in || (dma_req_in && !cool_q)) owner_d = OWN_TURN;
            end
            OWN_HCI: begin
                if (!hci_req_in) owner_d = OWN_TURN;
            end
            OWN_DMA: begin
                if (hold_q == HOLD_LAST) begin
                    owner_d = OWN_TURN;
                    cool_d  = 1'b1;
                end else if (hci_req_in || !dma_req_in) begin
                    owner_d = OWN_TURN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            OWN_TURN: begin
                if (hci_req_in)                  owner_d = OWN_HCI;
                else if (dma_req_in && !cool_q)  owner_d = OWN_DMA;
                else                             owner_d = OWN_CPU;
            end
            default: owner_d = OWN_CPU;
        endcase
    end

    // Shared bus follows the owner; parked while in TURN or held in reset
    always_comb begin
        mc_a_out    = IDLE_ADDR;
        mc_r_nw_out = 1'b1;
        mc_d_out    = '0;
        if (nrst_in) begin
            case (owner_q)
                OWN_CPU: begin
                    mc_a_out    = cpu_a_in;
                    mc_r_nw_out = cpu_r_nw_in;
                    mc_d_out    = cpu_d_in;
                end
                OWN_HCI: begin
                    mc_a_out    = hci_a_in;
                    mc_r_nw_out = hci_r_nw_in;
                    mc_d_out    = hci_d_in;
                end
                OWN_DMA: begin
                    mc_a_out    = dma_a_in;
                    mc_r_nw_out = dma_r_nw_in;
                    mc_d_out    = dma_d_in;
                end
                default: ;
            endcase
        end
    end

    assign owner_out   = owner_q;
    assign cpu_rdy_out = (owner_q == OWN_CPU);
    assign hci_gnt_out = (owner_q == OWN_HCI);
    assign dma_gnt_out = (owner_q == OWN_DMA);
    assign rd_d_out    = mc_d_in;
    assign rd_vld_out  = tag_rd_q ? (3'b001 << tag_own_q) : 3'b000;

`ifdef CPUMC_ARB_STATS_EN
    logic [STALL_W-1:0] stall_q;

    // Saturating count of cycles the CPU is held off the bus; clear wins
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            stall_q <= '0;
        end else if (stat_clr_in) begin
            stall_q <= '0;
        end else if (!cpu_rdy_out && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_out = stall_q;
`endif

endmodule

// File: tb/tb_cpumc_arb.sv
// Self-checking bench for cpumc_arb: directed scenarios plus random requests,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_cpumc_arb;

    localparam int DMAX = 513;

    logic        clk_in = 1'b0;
    logic        nrst_in;
    logic [15:0] cpu_a_in, hci_a_in, dma_a_in;
    logic        cpu_r_nw_in, hci_r_nw_in, dma_r_nw_in;
    logic [7:0]  cpu_d_in, hci_d_in, dma_d_in;
    logic        hci_req_in, dma_req_in;
    logic        cpu_rdy_out, hci_gnt_out, dma_gnt_out;
    logic [15:0] mc_a_out;
    logic        mc_r_nw_out;
    logic [7:0]  mc_d_out, mc_d_in, rd_d_out;
    logic [2:0]  rd_vld_out;
    logic [1:0]  owner_out;
`ifdef CPUMC_ARB_STATS_EN
    logic        stat_clr_in;
    logic [15:0] stall_cnt_out;
`endif

    cpumc_arb #(.DMA_MAX(DMAX)) dut (
        .clk_in        (clk_in),
        .nrst_in       (nrst_in),
        .cpu_a_in      (cpu_a_in),
        .cpu_r_nw_in   (cpu_r_nw_in),
        .cpu_d_in      (cpu_d_in),
        .cpu_rdy_out   (cpu_rdy_out),
        .hci_req_in    (hci_req_in),
        .hci_gnt_out   (hci_gnt_out),
        .hci_a_in      (hci_a_in),
        .hci_r_nw_in   (hci_r_nw_in),
        .hci_d_in      (hci_d_in),
        .dma_req_in    (dma_req_in),
        .dma_gnt_out   (dma_gnt_out),
        .dma_a_in      (dma_a_in),
        .dma_r_nw_in   (dma_r_nw_in),
        .dma_d_in      (dma_d_in),
        .mc_a_out      (mc_a_out),
        .mc_r_nw_out   (mc_r_nw_out),
        .mc_d_out      (mc_d_out),
        .mc_d_in       (mc_d_in),
        .rd_d_out      (rd_d_out),
        .rd_vld_out    (rd_vld_out),
        .owner_out     (owner_out)
`ifdef CPUMC_ARB_STATS_EN
        ,
        .stat_clr_in   (stat_clr_in),
        .stall_cnt_out (stall_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Model: 0 CPU, 1 HCI, 2 DMA, 3 TURN
    int m_own;
    int m_run;        // DMA cycles completed in the current tenure
    bit m_cool;       // set by a capped tenure, cleared by a CPU cycle
    bit m_tag_rd;
    int m_tag_own;
    int m_stall;

    logic [15:0] e_a;
    logic        e_rnw;
    logic [7:0]  e_d;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_bus();
        case (m_own)
            0: begin e_a = cpu_a_in; e_rnw = cpu_r_nw_in; e_d = cpu_d_in; end
            1: begin e_a = hci_a_in; e_rnw = hci_r_nw_in; e_d = hci_d_in; end
            2: begin e_a = dma_a_in; e_rnw = dma_r_nw_in; e_d = dma_d_in; end
            default: begin e_a = 16'h5000; e_rnw = 1'b1; e_d = 8'h00; end
        endcase
    endtask

    task automatic model_reset();
        m_own = 0; m_run = 0; m_cool = 0; m_tag_rd = 0; m_tag_own = 0; m_stall = 0;
    endtask

    // Compare every output against the model for the current cycle
    task automatic settle();
        #1;
        exp_bus();
        chk("owner",   owner_out,   m_own);
        chk("cpu_rdy", cpu_rdy_out, m_own == 0);
        chk("hci_gnt", hci_gnt_out, m_own == 1);
        chk("dma_gnt", dma_gnt_out, m_own == 2);
        chk("mc_a",    mc_a_out,    e_a);
        chk("mc_r_nw", mc_r_nw_out, e_rnw);
        chk("mc_d",    mc_d_out,    e_d);
        chk("rd_vld",  rd_vld_out,  m_tag_rd ? (32'd1 << m_tag_own) : 32'd0);
        chk("rd_d",    rd_d_out,    mc_d_in);
`ifdef CPUMC_ARB_STATS_EN
        chk("stall",   stall_cnt_out, m_stall);
`endif
    endtask

    // Apply the arbitration rules to the inputs present at the coming edge
    task automatic advance();
        int  n_own;
        int  n_run;
        bit  n_cool;
        n_own  = m_own;
        n_run  = m_run;
        n_cool = m_cool;
        exp_bus();
        case (m_own)
            0: begin
                n_cool = 0;
                if (hci_req_in || (dma_req_in && !m_cool)) n_own = 3;
            end
            1: if (!hci_req_in) n_own = 3;
            2: begin
                n_run = m_run + 1;
                if (n_run == DMAX) begin n_own = 3; n_cool = 1; end
                else if (hci_req_in || !dma_req_in) n_own = 3;
            end
            default: begin
                if (hci_req_in) n_own = 1;
                else if (dma_req_in && !m_cool) n_own = 2;
                else n_own = 0;
            end
        endcase
        if (n_own != 2) n_run = 0;
`ifdef CPUMC_ARB_STATS_EN
        if (stat_clr_in) m_stall = 0;
        else if (m_own != 0 && m_stall < 65535) m_stall++;
`endif
        @(posedge clk_in);
        #1;
        mc_d_in   = mem_rd(e_a);
        m_tag_rd  = (m_own != 3) && e_rnw;
        m_tag_own = m_own;
        m_own     = n_own;
        m_run     = n_run;
        m_cool    = n_cool;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        int n;
        nrst_in = 1'b0;
        cpu_a_in = 16'h1234; cpu_r_nw_in = 1'b0; cpu_d_in = 8'h11;
        hci_a_in = 16'h0300; hci_r_nw_in = 1'b1; hci_d_in = 8'h22;
        dma_a_in = 16'h0200; dma_r_nw_in = 1'b1; dma_d_in = 8'h33;
        hci_req_in = 1'b0; dma_req_in = 1'b0; mc_d_in = 8'h00;
`ifdef CPUMC_ARB_STATS_EN
        stat_clr_in = 1'b0;
`endif
        model_reset();

        // Reset values, with the CPU presenting a write the bus must ignore
        @(posedge clk_in); #1;
        chk("rst_owner",   owner_out,   0);
        chk("rst_rdy",     cpu_rdy_out, 1);
        chk("rst_hgnt",    hci_gnt_out, 0);
        chk("rst_dgnt",    dma_gnt_out, 0);
        chk("rst_rd_vld",  rd_vld_out,  0);
        chk("rst_mc_r_nw", mc_r_nw_out, 1);
        @(posedge clk_in); #1;
        nrst_in = 1'b1;
        cpu_r_nw_in = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // HCI takes the bus right after a CPU read of 0x0010
        cpu_a_in = 16'h0010; cpu_r_nw_in = 1'b1; hci_req_in = 1'b1;
        settle();
        chk("t38_cpu", owner_out, 0);
        advance();
        cpu_a_in = 16'h2222;
        settle();
        chk("t38_turn",    owner_out,   3);
        chk("t38_rdy_lo",  cpu_rdy_out, 0);
        chk("t39_rd_vld",  rd_vld_out,  3'b001);
        chk("t39_rd_data", rd_d_out,    8'h4A);
        advance();
        settle();
        chk("t38_hci",  owner_out,   1);
        chk("t38_hgnt", hci_gnt_out, 1);
        advance();
        hci_r_nw_in = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        hci_req_in = 1'b0; hci_r_nw_in = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // DMA burst suspended by HCI, then resumed
        dma_req_in = 1'b1;
        n = 0;
        settle();
        while (dma_gnt_out !== 1'b1 && n < 8) begin advance(); settle(); n++; end
        chk("t41_dma_start", dma_gnt_out, 1);
        advance();
        for (int i = 0; i < 3; i++) cyc();
        hci_req_in = 1'b1;
        settle();
        chk("t41_dma", owner_out, 2);
        advance(); settle();
        chk("t41_turn1", owner_out, 3);
        advance(); settle();
        chk("t41_hci", owner_out, 1);
        advance();
        for (int i = 0; i < 3; i++) cyc();
        hci_req_in = 1'b0;
        settle();
        chk("t41_hci_last", owner_out, 1);
        advance(); settle();
        chk("t41_turn2", owner_out, 3);
        advance(); settle();
        chk("t41_resume", dma_gnt_out, 1);

        // Held DMA request: capped tenure, CPU gap, DMA again
        n = 0;
        while (dma_gnt_out === 1'b1 && n < 700) begin
            n++;
            dma_a_in = 16'($urandom_range(16'h0200, 16'h02FF));
            advance(); settle();
        end
        chk("t40_gnt_run", n, DMAX);
        chk("t40_turn1", owner_out, 3);
        advance(); settle();
        n = 0;
        while (owner_out === 2'd0 && n < 20) begin n++; advance(); settle(); end
        chk("t40_cpu_gap", n >= 1, 1);
        chk("t40_turn2", owner_out, 3);
        advance(); settle();
        chk("t40_dma_again", dma_gnt_out, 1);
        advance();

        // Reset pulsed in the middle of a DMA read tenure
        dma_r_nw_in = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        #2;
        nrst_in = 1'b0;
        #1;
        chk("t42_owner",   owner_out,   0);
        chk("t42_dgnt",    dma_gnt_out, 0);
        chk("t42_rd_vld",  rd_vld_out,  0);
        chk("t42_rdy",     cpu_rdy_out, 1);
        chk("t42_mc_r_nw", mc_r_nw_out, 1);
        model_reset();
        @(posedge clk_in); #1;
        chk("t42_rd_vld_hold", rd_vld_out, 0);
        dma_req_in = 1'b0;
        nrst_in = 1'b1;
        for (int i = 0; i < 2; i++) cyc();

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            cpu_a_in = 16'($urandom); cpu_r_nw_in = 1'($urandom); cpu_d_in = 8'($urandom);
            hci_a_in = 16'($urandom); hci_r_nw_in = 1'($urandom); hci_d_in = 8'($urandom);
            dma_a_in = 16'($urandom); dma_r_nw_in = 1'($urandom); dma_d_in = 8'($urandom);
            if ($urandom_range(0, 29) == 0) hci_req_in = ~hci_req_in;
            if ($urandom_range(0, 11) == 0) dma_req_in = ~dma_req_in;
            cyc();
        end

`ifdef CPUMC_ARB_STATS_EN
        // Saturation of the stall counter, then a clear during a stall
        dma_req_in = 1'b0;
        hci_req_in = 1'b1;
        for (int i = 0; i < 70005; i++) cyc();
        settle();
        chk("t43_sat", stall_cnt_out, 16'hFFFF);
        stat_clr_in = 1'b1;
        advance();
        settle();
        chk("t43_clr", stall_cnt_out, 16'h0000);
        stat_clr_in = 1'b0;
        hci_req_in = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpumc_arb.md
CPUMC_ARB -- requirements
Module: cpumc_arb

Interface
REQ-001 SHALL have parameter DMA_MAX, default 513, the maximum consecutive DMA-owned cycles (legal range 2..1023).
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port nrst_in  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cpu_a_in  input  16  CPU address.
REQ-005 SHALL have port cpu_r_nw_in  input  1  CPU read(1)/write(0).
REQ-006 SHALL have port cpu_d_in  input  8  CPU write data.
REQ-007 SHALL have port cpu_rdy_out  output  1  CPU may advance; high only while CPU owns the bus.
REQ-008 SHALL have port hci_req_in  input  1  debug host bus request, level-held for the whole tenure.
REQ-009 SHALL have port hci_gnt_out  output  1  HCI owns the bus this cycle.
REQ-010 SHALL have port hci_a_in  input  16  HCI address.
REQ-011 SHALL have port hci_r_nw_in  input  1  HCI read/write.
REQ-012 SHALL have port hci_d_in  input  8  HCI write data.
REQ-013 SHALL have port dma_req_in  input  1  sprite-DMA bus request, level-held.
REQ-014 SHALL have port dma_gnt_out  output  1  DMA owns the bus this cycle.
REQ-015 SHALL have port dma_a_in  input  16  DMA address.
REQ-016 SHALL have port dma_r_nw_in  input  1  DMA read/write.
REQ-017 SHALL have port dma_d_in  input  8  DMA write data.
REQ-018 SHALL have port mc_a_out  output  16  shared memory-bus address.
REQ-019 SHALL have port mc_r_nw_out  output  1  shared bus read/write.
REQ-020 SHALL have port mc_d_out  output  8  shared bus write data.
REQ-021 SHALL have port mc_d_in  input  8  shared bus read data, valid one cycle after its address.
REQ-022 SHALL have port rd_d_out  output  8  read data to all requesters, equal to mc_d_in.
REQ-023 SHALL have port rd_vld_out  output  3  one-hot {dma,hci,cpu} read-return strobe.
REQ-024 SHALL have port owner_out  output  2  current owner: 0 CPU, 1 HCI, 2 DMA, 3 TURN.

Function
REQ-025 SHALL implement states CPU, HCI, DMA and TURN, and every ownership change SHALL pass through exactly one TURN cycle.
REQ-026 SHALL, while in CPU, go to TURN if hci_req_in is high, or if dma_req_in is high and cooldown is clear.
REQ-027 SHALL, while in HCI, go to TURN when hci_req_in is low.
REQ-028 SHALL, while in DMA, go to TURN when hci_req_in is high (suspend), when dma_req_in is low, or when the hold counter reaches DMA_MAX-1; the cap case SHALL set cooldown.
REQ-029 SHALL, on leaving TURN, re-arbitrate with priority HCI > DMA (only if cooldown is clear) > CPU.
REQ-030 SHALL clear cooldown after one CPU-owned cycle.
REQ-031 SHALL drive mc_* from the owner's inputs combinationally; in TURN, mc_a_out SHALL be IDLE_ADDR (16'h5000, unmapped), mc_r_nw_out SHALL be 1 and mc_d_out SHALL be 0.
REQ-032 SHALL register a read tag each cycle, and rd_vld_out SHALL assert the previous cycle's owner bit only if that cycle was a non-TURN read.
REQ-033 SHALL use a 10-bit hold counter that increments on each DMA-owned cycle and clears on any DMA exit; a DMA request suspended by HCI SHALL resume with the counter restarted.

Reset
REQ-034 SHALL, while nrst_in is low, force owner=CPU, cpu_rdy_out=1, both gnts=0, rd_vld_out=0, mc_r_nw_out=1, counters=0 and cooldown=0; reset mid-tenure SHALL abandon it without a TURN.

Configuration
REQ-035 SHALL, when CPUMC_ARB_STATS_EN is defined, add port stat_clr_in (input, 1) and port stall_cnt_out (output, 16), a saturating count of cycles with cpu_rdy_out=0; clear SHALL win over increment. Without the macro, neither port nor counter SHALL exist.

Structure
REQ-036 SHALL place the owner encoding enum, IDLE_ADDR and the counter widths in shared package nes_bus_pkg.
REQ-037 SHALL be a single module with no sub-modules.

Verification
REQ-038 Bench SHALL cover: hci_req_in rises while CPU owns -> owner CPU,TURN,HCI on consecutive cycles, cpu_rdy_out low from the TURN cycle.
REQ-039 Bench SHALL cover: CPU read of 16'h0010 in the cycle before the switch -> rd_vld_out=3'b001 with that data during TURN.
REQ-040 Bench SHALL cover: dma_req_in held for 600 cycles, DMA_MAX=513 -> exactly 513 gnt cycles, TURN, at least 1 CPU cycle, TURN, DMA again.
REQ-041 Bench SHALL cover: hci_req_in during a DMA burst -> DMA,TURN,HCI; on HCI release, TURN,DMA with dma_gnt_out high.
REQ-042 Bench SHALL cover: nrst_in pulsed low mid-DMA -> owner=0 and dma_gnt_out=0 immediately, with no rd_vld_out pulse.
REQ-043 Bench SHALL cover: with CPUMC_ARB_STATS_EN, 70000 stall cycles -> stall_cnt_out=16'hFFFF; stat_clr_in held during a stall -> 0.
